// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding
// and the width helper for the LED hold counter.
package seq_detector_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  // Bits needed to hold a down-counter loaded with 'hold'.
  function automatic int hold_width(input int hold);
    return (hold < 2) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_pulse_stretch.sv
// Pulse stretcher: out rises on the edge that sees trig and stays high for
// HOLD cycles after the most recent trigger (retriggerable).
module pulse_stretch
  import seq_detector_param_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic out
);

  localparam int HW = hold_width(HOLD);

  logic [HW-1:0] hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      out  <= 1'b0;
    end else if (trig) begin
      hold <= HW'(HOLD);
      out  <= 1'b1;
    end else if (hold > HW'(1)) begin
      hold <= hold - HW'(1);
    end else begin
      hold <= '0;
      out  <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern,
// selectable overlap, saturating match counter and stretched LED output.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int               PAT_W    = 3,
  parameter logic [PAT_W-1:0] RST_PAT  = 3'b101,
  parameter int               CNT_W    = 8,
  parameter int               LED_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal,
  input  logic             sample_en,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             led
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  state_t             state;
  logic [PAT_W-1:0]   history;
  logic [PAT_W-1:0]   pattern;
  logic               overlap;
  logic [FILL_W-1:0]  fill;
  logic [PAT_W-1:0]   shifted;
  logic               hit;

  assign shifted = {history[PAT_W-2:0], signal};

  // fill >= PAT_W-1 means the window is full once this bit is shifted in.
  assign hit = sample_en && !cfg_load &&
               (fill >= FILL_W'(PAT_W - 1)) && (shifted == pattern);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      history   <= '0;
      pattern   <= RST_PAT;
      overlap   <= 1'b1;
      fill      <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= 1'b0;
      if (cfg_load) begin
        pattern <= cfg_pattern;
        overlap <= cfg_overlap;
        fill    <= '0;
        state   <= ST_IDLE;
      end else if (sample_en) begin
        history <= shifted;
        if (hit) begin
          match <= 1'b1;
          if (match_cnt != {CNT_W{1'b1}})
            match_cnt <= match_cnt + CNT_W'(1);
        end
        if (hit && !overlap) begin
          fill  <= '0;
          state <= ST_IDLE;
        end else begin
          case (state)
            ST_IDLE: begin
              fill  <= FILL_W'(1);
              state <= ST_FILL;
            end
            ST_FILL: begin
              fill <= fill + FILL_W'(1);
              if (fill == FILL_W'(PAT_W - 1))
                state <= ST_ARMED;
            end
            ST_ARMED: state <= ST_ARMED;
            default: begin
              fill  <= '0;
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  pulse_stretch #(
    .HOLD(LED_HOLD)
  ) u_led (
    .clk (clk),
    .rst (rst),
    .trig(hit),
    .out (led)
  );

endmodule
